// File: rtl/stage_4_mem.sv
// Memory-access pipeline stage: registers the EX bus, extends synchronous SRAM load
// data, selects the final result and drives the WB bus plus a forwarding path to ID.
module stage_4_mem #(
   parameter int IN_W  = 74,
   parameter int OUT_W = 70
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_3,
   output logic             allow_4,
   input  logic [IN_W-1:0]  stage_3_to_4,
   input  logic [31:0]      data_sram_rdata,
   output logic             valid_4,
   input  logic             allow_5,
   output logic [OUT_W-1:0] stage_4_to_5,
   output logic             mem_fwd_we,
   output logic [4:0]       mem_fwd_dest,
   output logic [31:0]      mem_fwd_data
);

   logic            valid_r;
   logic            first_r;
   logic [IN_W-1:0] bus_r;
   logic [31:0]     rdata_hold;
   logic            ready_go;

   logic [2:0]  ld_op;
   logic        res_from_mem;
   logic        rf_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic [31:0] mem_data;
   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] final_result;

   assign ready_go = 1'b1;
   assign allow_4  = !valid_r || (ready_go && allow_5);
   assign valid_4  = valid_r && ready_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r    <= 1'b0;
         first_r    <= 1'b0;
         bus_r      <= '0;
         rdata_hold <= '0;
      end else begin
         if (allow_4) begin
            valid_r <= valid_3;
         end
         if (valid_3 && allow_4) begin
            bus_r <= stage_3_to_4;
         end
         first_r <= valid_3 && allow_4;
         // SRAM data is only presented in the first cycle; keep it for WB stalls
         if (first_r) begin
            rdata_hold <= data_sram_rdata;
         end
      end
   end

   assign {ld_op, res_from_mem, rf_we, dest, alu_result, pc} = bus_r;

   assign mem_data = first_r ? data_sram_rdata : rdata_hold;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = mem_data[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane[alu_result[1:0]];
   assign half_sel = alu_result[1] ? mem_data[31:16] : mem_data[15:0];

   always_comb begin
      load_data = mem_data;
      case (ld_op)
         3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd2:    load_data = {24'h0, byte_sel};
         3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd4:    load_data = {16'h0, half_sel};
         default: load_data = mem_data;
      endcase
   end

   assign final_result = res_from_mem ? load_data : alu_result;

   assign stage_4_to_5 = {rf_we, dest, final_result, pc};
   assign mem_fwd_we   = valid_r && rf_we && (dest != 5'd0);
   assign mem_fwd_dest = dest;
   assign mem_fwd_data = final_result;

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: reset, table of load extensions, hand-written stall/reset
// sequences and a randomized run against a slot-level reference model.
module tb_stage_4_mem;

   logic        clk;
   logic        reset;
   logic        valid_3;
   logic        allow_4;
   logic [73:0] stage_3_to_4;
   logic [31:0] data_sram_rdata;
   logic        valid_4;
   logic        allow_5;
   logic [69:0] stage_4_to_5;
   logic        mem_fwd_we;
   logic [4:0]  mem_fwd_dest;
   logic [31:0] mem_fwd_data;

   int checks = 0;
   int errors = 0;

   stage_4_mem #(.IN_W(74), .OUT_W(70)) dut (
      .clk(clk),
      .reset(reset),
      .valid_3(valid_3),
      .allow_4(allow_4),
      .stage_3_to_4(stage_3_to_4),
      .data_sram_rdata(data_sram_rdata),
      .valid_4(valid_4),
      .allow_5(allow_5),
      .stage_4_to_5(stage_4_to_5),
      .mem_fwd_we(mem_fwd_we),
      .mem_fwd_dest(mem_fwd_dest),
      .mem_fwd_data(mem_fwd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]  op;
      logic        rfm;
      logic [1:0]  off;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [73:0] pack(input logic [2:0] op, input logic rfm, input logic we,
                                        input logic [4:0] d, input logic [31:0] alu,
                                        input logic [31:0] p);
      return {op, rfm, we, d, alu, p};
   endfunction

   // Reference: extract by shifting and masking, extend by arithmetic on the value
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [31:0] b;
      logic [31:0] h;
      b = (d >> (8 * off)) & 32'hFF;
      h = (d >> (16 * off[1])) & 32'hFFFF;
      case (op)
         3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return h;
         default: return d;
      endcase
   endfunction

   function automatic logic [69:0] ref_bus(input logic [73:0] ins, input logic [31:0] d);
      logic [31:0] res;
      res = ins[70] ? ref_load(ins[73:71], ins[33:32], d) : ins[63:32];
      return {ins[69], ins[68:64], res, ins[31:0]};
   endfunction

   vec_t vecs[12];

   // reference model state
   logic        m_valid;
   logic        m_first;
   logic [73:0] m_instr;
   logic [31:0] m_data;

   initial begin
      logic [73:0] ins;
      logic [69:0] held;
      logic [31:0] d;
      logic        a5;
      logic        v3;
      logic        accept;
      logic [69:0] exp_bus;

      vecs[0]  = '{3'd1, 1'b1, 2'd0, 32'h80FF7F01, 32'h00000001};
      vecs[1]  = '{3'd1, 1'b1, 2'd1, 32'h80FF7F01, 32'h0000007F};
      vecs[2]  = '{3'd1, 1'b1, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
      vecs[3]  = '{3'd1, 1'b1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
      vecs[4]  = '{3'd2, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080};
      vecs[5]  = '{3'd3, 1'b1, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
      vecs[6]  = '{3'd4, 1'b1, 2'd2, 32'h80FF7F01, 32'h000080FF};
      vecs[7]  = '{3'd3, 1'b1, 2'd0, 32'h80FF7F01, 32'h00007F01};
      vecs[8]  = '{3'd4, 1'b1, 2'd3, 32'h80FF7F01, 32'h000080FF};
      vecs[9]  = '{3'd0, 1'b1, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
      vecs[10] = '{3'd6, 1'b1, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
      vecs[11] = '{3'd1, 1'b0, 2'd3, 32'h80FF7F01, 32'h1c000103};

      reset           = 1'b1;
      valid_3         = 1'b0;
      allow_5         = 1'b0;
      stage_3_to_4    = '0;
      data_sram_rdata = '0;
      #1;
      chk("reset_valid_4", 70'(valid_4), 70'd0);
      chk("reset_allow_4", 70'(allow_4), 70'd1);
      chk("reset_bus", stage_4_to_5, 70'h0);
      chk("reset_fwd_we", 70'(mem_fwd_we), 70'd0);
      @(negedge clk);
      reset = 1'b0;

      // ALU result passes straight through
      @(negedge clk);
      valid_3      = 1'b1;
      allow_5      = 1'b1;
      stage_3_to_4 = pack(3'd0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000010);
      @(negedge clk);
      valid_3 = 1'b0;
      #1;
      chk("alu_valid_4", 70'(valid_4), 70'd1);
      chk("alu_bus", stage_4_to_5, {1'b1, 5'd5, 32'h12345678, 32'h1c000010});
      chk("alu_fwd_we", 70'(mem_fwd_we), 70'd1);
      chk("alu_fwd_dest", 70'(mem_fwd_dest), 70'd5);
      chk("alu_fwd_data", 70'(mem_fwd_data), 70'h12345678);
      $display("xfer pc=1c000010 result=12345678");
      @(negedge clk);
      #1;
      chk("bubble_valid_4", 70'(valid_4), 70'd0);
      chk("bubble_fwd_we", 70'(mem_fwd_we), 70'd0);

      // dest 0 never forwards
      @(negedge clk);
      valid_3      = 1'b1;
      stage_3_to_4 = pack(3'd0, 1'b0, 1'b1, 5'd0, 32'h0000ABCD, 32'h1c000014);
      @(negedge clk);
      valid_3 = 1'b0;
      #1;
      chk("dest0_valid_4", 70'(valid_4), 70'd1);
      chk("dest0_fwd_we", 70'(mem_fwd_we), 70'd0);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         valid_3      = 1'b1;
         allow_5      = 1'b1;
         stage_3_to_4 = pack(vecs[i].op, vecs[i].rfm, 1'b1, 5'd3, 32'h1c000100 | 32'(vecs[i].off),
                             32'h1c000200 + 32'(i * 4));
         data_sram_rdata = 32'h0;
         @(negedge clk);
         valid_3         = 1'b0;
         data_sram_rdata = vecs[i].rdata;
         #1;
         chk($sformatf("load_vec%0d", i), 70'(stage_4_to_5[63:32]), 70'(vecs[i].exp));
         $display("xfer vec%0d op=%0d off=%0d result=%08h", i, vecs[i].op, vecs[i].off,
                  stage_4_to_5[63:32]);
      end

      // WB stall on a load: data and bus must survive, and leave exactly once
      @(negedge clk);
      valid_3         = 1'b1;
      allow_5         = 1'b0;
      stage_3_to_4    = pack(3'd0, 1'b1, 1'b1, 5'd7, 32'h1c000300, 32'h1c000040);
      @(negedge clk);
      data_sram_rdata = 32'h11223344;
      stage_3_to_4    = pack(3'd0, 1'b0, 1'b1, 5'd9, 32'h55555555, 32'h1c000044);
      #1;
      held = stage_4_to_5;
      chk("stall_c1_valid_4", 70'(valid_4), 70'd1);
      chk("stall_c1_allow_4", 70'(allow_4), 70'd0);
      chk("stall_c1_bus", stage_4_to_5, {1'b1, 5'd7, 32'h11223344, 32'h1c000040});
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         data_sram_rdata = 32'hDEADBEEF;
         #1;
         chk($sformatf("stall_c%0d_allow_4", c), 70'(allow_4), 70'd0);
         chk($sformatf("stall_c%0d_bus", c), stage_4_to_5, held);
      end
      @(negedge clk);
      allow_5 = 1'b1;
      valid_3 = 1'b0;
      #1;
      chk("stall_rel_valid_4", 70'(valid_4), 70'd1);
      chk("stall_rel_allow_4", 70'(allow_4), 70'd1);
      chk("stall_rel_bus", stage_4_to_5, held);
      $display("xfer pc=1c000040 result=%08h", stage_4_to_5[63:32]);
      @(negedge clk);
      #1;
      chk("stall_once", 70'(valid_4), 70'd0);

      // async reset during a stall
      @(negedge clk);
      valid_3      = 1'b1;
      allow_5      = 1'b0;
      stage_3_to_4 = pack(3'd0, 1'b0, 1'b1, 5'd4, 32'h0BADF00D, 32'h1c000050);
      @(negedge clk);
      valid_3 = 1'b0;
      #1;
      chk("arst_pre_valid_4", 70'(valid_4), 70'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_valid_4", 70'(valid_4), 70'd0);
      chk("arst_allow_4", 70'(allow_4), 70'd1);
      chk("arst_bus", stage_4_to_5, 70'h0);
      @(negedge clk);
      reset        = 1'b0;
      valid_3      = 1'b1;
      allow_5      = 1'b1;
      stage_3_to_4 = pack(3'd0, 1'b0, 1'b1, 5'd6, 32'hCAFEF00D, 32'h1c000060);
      @(negedge clk);
      valid_3 = 1'b0;
      #1;
      chk("arst_after_valid_4", 70'(valid_4), 70'd1);
      chk("arst_after_bus", stage_4_to_5, {1'b1, 5'd6, 32'hCAFEF00D, 32'h1c000060});
      $display("xfer pc=1c000060 result=cafef00d");

      // randomized run against the slot model
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      m_valid = 1'b0;
      m_first = 1'b0;
      m_instr = '0;
      m_data  = '0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         v3 = ($urandom_range(0, 3) != 0);
         a5 = ($urandom_range(0, 2) != 0);
         valid_3         = v3;
         allow_5         = a5;
         stage_3_to_4    = pack(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                                5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
                                $urandom, $urandom);
         data_sram_rdata = $urandom;
         #1;
         d = m_first ? data_sram_rdata : m_data;
         chk("rnd_valid_4", 70'(valid_4), 70'(m_valid));
         chk("rnd_allow_4", 70'(allow_4), 70'(!m_valid || a5));
         if (m_valid) begin
            exp_bus = ref_bus(m_instr, d);
            chk("rnd_bus", stage_4_to_5, exp_bus);
            chk("rnd_fwd_we", 70'(mem_fwd_we), 70'(m_instr[69] && (m_instr[68:64] != 5'd0)));
            chk("rnd_fwd_dest", 70'(mem_fwd_dest), 70'(m_instr[68:64]));
            chk("rnd_fwd_data", 70'(mem_fwd_data), 70'(exp_bus[63:32]));
         end else begin
            chk("rnd_fwd_we_idle", 70'(mem_fwd_we), 70'd0);
         end
         // clock edge in the model
         accept = !m_valid || a5;
         if (m_first) m_data = data_sram_rdata;
         if (accept) begin
            if (m_valid) $display("xfer pc=%08h result=%08h", m_instr[31:0], exp_bus[63:32]);
            m_valid = v3;
            if (v3) m_instr = stage_3_to_4;
         end
         m_first = v3 && accept;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
